// File: rtl/prbs_variable_pkg.sv
// prbs_variable_pkg: length encodings, lengths and feedback tap positions for prbs_variable
package prbs_variable_pkg;
  typedef enum logic [1:0] {
    LEN_30  = 2'b00,
    LEN_25  = 2'b01,
    LEN_RSV = 2'b10,
    LEN_20  = 2'b11
  } len_e;
  localparam int L30 = 30;
  localparam int L25 = 25;
  localparam int L20 = 20;
  localparam int T30_A = 29;
  localparam int T30_B = 5;
  localparam int T30_C = 3;
  localparam int T30_D = 0;
  localparam int T25_A = 24;
  localparam int T25_B = 21;
  localparam int T20_A = 19;
  localparam int T20_B = 16;
  // Reserved encoding aliases the full 30-stage register.
  function automatic int len_of(len_e sel);
    return sel == LEN_25 ? L25 : sel == LEN_20 ? L20 : L30;
  endfunction
endpackage

// File: rtl/prbs_variable.sv
// prbs_variable: Fibonacci LFSR PRBS generator with selectable 30/25/20-stage length
module prbs_variable
  import prbs_variable_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [0:29] Semilla,
  input  logic [0:1]  Longitud,
  output logic        Salida
);
  len_e        sel;
  logic [0:29] sr;
  logic [0:29] seed;
  logic [0:29] sr_next;
  logic [4:0]  out_idx;
  logic        fb;
  logic        zero;
  assign sel = len_e'(Longitud);
  assign out_idx = 5'(len_of(sel) - 1);
  always_comb begin
    fb = sel == LEN_25 ? sr[T25_A] ^ sr[T25_B] :
         sel == LEN_20 ? sr[T20_A] ^ sr[T20_B] :
         sr[T30_A] ^ sr[T30_B] ^ sr[T30_C] ^ sr[T30_D];
    zero = sel == LEN_25 ? ~|Semilla[0:24] :
           sel == LEN_20 ? ~|Semilla[0:19] :
           ~|Semilla;
    seed = {Semilla[0] | zero, Semilla[1:29]};
    sr_next = {fb, sr[0:28]};
  end
  // Salida is registered from the value sr takes at this edge, so it always equals sr[L-1].
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sr <= seed;
      Salida <= seed[out_idx];
    end else begin
      sr <= sr_next;
      Salida <= sr_next[out_idx];
    end
  end
endmodule

// File: tb/tb_prbs_variable.sv
// tb_prbs_variable: table vectors, directed sequences and randomized run against a bit-sequence model
module tb_prbs_variable;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [0:29] Semilla = '0;
  logic [0:1]  Longitud = 2'b00;
  logic        Salida;
  int checks = 0;
  int fails = 0;
  bit h[$];
  int m_len = 30;
  typedef struct {
    logic [0:29] seed;
    logic [0:1]  len;
    logic        want;
  } vec_t;
  vec_t tbl[9];
  logic [0:29] seq_seed = 30'b101100111010111011001110010100;
  logic [0:29] seq_out  = 30'b001010011100110111010111001101;
  always #5 Clk = ~Clk;
  prbs_variable dut (
    .Clk(Clk),
    .Reset(Reset),
    .Semilla(Semilla),
    .Longitud(Longitud),
    .Salida(Salida)
  );
  function automatic int len_m(logic [0:1] l);
    return l == 2'b01 ? 25 : l == 2'b11 ? 20 : 30;
  endfunction
  function automatic bit mout();
    return h[m_len-1];
  endfunction
  task automatic check(string name, logic act, logic want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, want);
    end
  endtask
  // h[k] is the bit generated k cycles ago, i.e. the current content of stage k+1.
  task automatic model_edge();
    int l;
    bit any;
    bit nb;
    l = len_m(Longitud);
    m_len = l;
    if (!Reset) begin
      any = 0;
      h.delete();
      for (int k = 0; k < 30; k++) h.push_back(Semilla[k]);
      for (int k = 0; k < l; k++) any |= h[k];
      if (!any) h[0] = 1'b1;
    end else begin
      nb = l == 30 ? h[29] ^ h[5] ^ h[3] ^ h[0] : l == 25 ? h[24] ^ h[21] : h[19] ^ h[16];
      h.push_front(nb);
      void'(h.pop_back());
    end
  endtask
  task automatic edge_step();
    @(posedge Clk);
    model_edge();
    #1;
  endtask
  initial begin
    bit saw;
    int l;
    tbl[0] = '{30'b000000000000000000000000000001, 2'b00, 1'b1};
    tbl[1] = '{30'b000000000000000000000000000001, 2'b01, 1'b0};
    tbl[2] = '{30'b000000000000000000000000000001, 2'b11, 1'b0};
    tbl[3] = '{30'b000000000000000000001000000000, 2'b11, 1'b0};
    tbl[4] = '{30'b000000000000000000010000000000, 2'b11, 1'b1};
    tbl[5] = '{30'b000000000000000000010000000000, 2'b00, 1'b0};
    tbl[6] = '{30'b000000000000000000000000100000, 2'b01, 1'b1};
    tbl[7] = '{30'b000000000000000000000000100000, 2'b10, 1'b0};
    tbl[8] = '{30'b111111111111111111111111111111, 2'b10, 1'b1};
    #2;
    Reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      Semilla = tbl[i].seed;
      Longitud = tbl[i].len;
      edge_step();
      check("reset_load", Salida, tbl[i].want);
    end
    Semilla = seq_seed;
    Longitud = 2'b00;
    edge_step();
    Reset = 1'b1;
    Semilla = 30'($urandom);
    for (int i = 0; i < 30; i++) begin
      check("seed_seq", Salida, seq_out[i]);
      edge_step();
    end
    for (int i = 30; i < 1000; i++) begin
      Semilla = 30'($urandom);
      check("run30", Salida, mout());
      edge_step();
    end
    Reset = 1'b0;
    Semilla = seq_seed;
    edge_step();
    Reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      check("replay", Salida, seq_out[i]);
      edge_step();
    end
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      edge_step();
      check("reset_hold", Salida, seq_out[0]);
    end
    Semilla = 30'b000000000000000000000000000001;
    edge_step();
    check("reset_reload", Salida, 1'b1);
    Reset = 1'b1;
    Semilla = seq_seed;
    for (int i = 0; i < 200; i++) begin
      edge_step();
      check("run_after_hold", Salida, mout());
    end
    Longitud = 2'b11;
    for (int i = 0; i < 100; i++) begin
      edge_step();
      check("switch_to_20", Salida, mout());
    end
    Longitud = 2'b01;
    for (int i = 0; i < 100; i++) begin
      edge_step();
      check("switch_to_25", Salida, mout());
    end
    for (int j = 0; j < 4; j++) begin
      Longitud = 2'(j);
      l = len_m(Longitud);
      Semilla = '0;
      Reset = 1'b0;
      edge_step();
      Reset = 1'b1;
      saw = 0;
      for (int i = 0; i < 60; i++) begin
        if (i == l - 1) check("zero_guard", Salida, 1'b1);
        check("zero_seq", Salida, mout());
        saw |= Salida;
        edge_step();
      end
      check("zero_nonconst", saw, 1'b1);
    end
    Semilla = 30'($urandom) | 30'h1;
    Reset = 1'b0;
    edge_step();
    Reset = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      Semilla = 30'($urandom);
      if ($urandom_range(0, 149) == 0) Longitud = 2'($urandom);
      Reset = $urandom_range(0, 99) == 0 ? 1'b0 : 1'b1;
      edge_step();
      check("random", Salida, mout());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/prbs_variable.md
PRBS_VARIABLE -- requirements
Module: prbs_variable

Interface
REQ-001 The block SHALL use one clock and synchronous active-low reset, with ports named Clk and Reset.
REQ-002 Clk  input  1  rising-edge clock; all state changes occur only on its rising edge.
REQ-003 Reset  input  1  synchronous active-low reset; 0 sampled at a rising Clk edge loads the seed.
REQ-004 Semilla  input  30, indexed [0:29]  seed value; bit 0 is the MSB (leftmost literal character).
REQ-005 Longitud  input  2, indexed [0:1]  LFSR length select: 00 = 30, 01 = 25, 11 = 20, 10 = 30 (reserved, aliases 00).
REQ-006 Salida  output  1  serial PRBS bit, driven directly from a register bit (no combinational path from inputs).

Function
REQ-007 State SHALL be a 30-bit shift register sr[0:29] in Fibonacci form; each non-reset edge: sr[k] <= sr[k-1] for k = 1..29, sr[0] <= fb.
REQ-008 Active length L SHALL be 30, 25 or 20 per REQ-005; Salida SHALL equal sr[L-1] at all times.
REQ-009 fb SHALL be the XOR of these maximal-length taps (stage n = sr[n-1]): L=30: sr[29]^sr[5]^sr[3]^sr[0]; L=25: sr[24]^sr[21]; L=20: sr[19]^sr[16].
REQ-010 For any nonzero seed in sr[0:L-1], the Salida sequence SHALL repeat with period exactly 2^L-1 cycles.
REQ-011 Bits sr[L..29] SHALL keep shifting but SHALL NOT affect fb or Salida.
REQ-012 A Longitud change while running SHALL take effect at the next edge: new taps and new output index, with no reseed and no other state disturbance.
REQ-013 Semilla SHALL be sampled only during reset; changes while Reset=1 SHALL be ignored.
REQ-014 The output sequence following reset SHALL start with sr[L-1], sr[L-2], ..., sr[0] of the loaded seed (the first L output bits are the seed prefix reversed).

Reset
REQ-015 On a rising edge with Reset=0: sr <= Semilla.
REQ-016 Zero-seed guard: if Semilla[0:L-1] is all zero for the current L, the load SHALL use Semilla with sr[0] forced to 1, to prevent lockup.
REQ-017 While Reset is held 0, sr SHALL reload every edge and Salida SHALL equal the loaded sr[L-1].
REQ-018 Reset asserted mid-sequence SHALL abort the sequence and restart it from the seed at that edge.
REQ-019 Before the first reset, the value of sr SHALL be undefined; no power-on value is required.

Structure
REQ-020 A shared package SHALL hold the 2-bit length encodings, the length constants (30/25/20) and the per-length tap index constants.
REQ-021 The design SHALL be a single module with no sub-modules; tap selection SHALL be a combinational function or case keyed on Longitud.

Verification
REQ-022 Semilla=30'b101100111010111011001110010100, Longitud=00, pulse Reset=0 for one edge -> the first 30 Salida bits are 0,0,1,0,1,0,0,1,1,1,0,0,1,1,0,1,1,1,0,1,0,1,1,1,0,0,1,1,0,1.
REQ-023 Longitud=11, any nonzero seed -> Salida period is exactly 1048575 cycles, and no shorter repeat of sr[0:19] occurs.
REQ-024 Longitud=01, any nonzero seed -> sr[0:24] returns to the seed after exactly 33554431 cycles.
REQ-025 Semilla=0, any Longitud -> after reset sr[0]=1 and the sequence is non-constant (not all zeros).
REQ-026 Reset=0 asserted mid-run (e.g., at cycle 1000) -> the next outputs replay the REQ-022 sequence from its first bit.
REQ-027 Switch Longitud 00->11 mid-run -> at the next edge Salida=sr[19] and fb uses the L=20 taps, with no glitch and no reseed.
